button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter N, default 16, meaning consecutive disagreeing cycles required before btn_clean changes; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port btn_raw, input, 1, asynchronous, bouncing push-button level.
REQ-005 SHALL have port btn_clean, output, 1, registered debounced level; it feeds the downstream rising-edge detector.
REQ-006 SHALL have port btn_press, output, 1, registered one-cycle pulse on a debounced 0->1 change.
REQ-007 SHALL have port btn_release, output, 1, registered one-cycle pulse on a debounced 1->0 change.
REQ-008 SHALL have port press_count, output, 8, registered count of btn_press pulses since reset, saturating.

Function
REQ-009 SHALL pass btn_raw through a two-flop synchronizer (s1 <- btn_raw, s2 <- s1); btn_sync = s2; no other logic reads btn_raw.
REQ-010 SHALL hold a stability counter cnt of width clog2(N), with at least 1 bit.
REQ-011 SHALL, on each edge where btn_sync == btn_clean, load cnt = 0 and leave btn_clean unchanged.
REQ-012 SHALL, on each edge where btn_sync != btn_clean and cnt < N-1, increment cnt by 1.
REQ-013 SHALL, on an edge where btn_sync != btn_clean and cnt == N-1, load btn_clean = btn_sync and cnt = 0.
REQ-014 SHALL result in btn_clean changing exactly N edges after btn_sync first differs, provided btn_sync stays constant for those N edges.
REQ-015 SHALL restart the count from 0 when btn_sync returns to btn_clean before N edges elapse, so any glitch shorter than N cycles is fully rejected.
REQ-016 SHALL give a total latency of N+2 rising edges from a stable btn_raw change to a btn_clean change.
REQ-017 SHALL assert btn_press for exactly the first cycle in which btn_clean is 1 after being 0; it is registered on the same edge that updates btn_clean.
REQ-018 SHALL assert btn_release for exactly the first cycle in which btn_clean is 0 after being 1; it is registered on the same edge.
REQ-019 SHALL never assert btn_press and btn_release in the same cycle, and never for two consecutive cycles.
REQ-020 SHALL increment press_count by 1 on the edge that asserts btn_press.
REQ-021 SHALL saturate press_count at 255, with no wrap-around.
REQ-022 SHALL make all outputs pure register outputs, with no combinational path from btn_raw.
REQ-023 SHALL drive outputs to X in simulation when btn_sync or btn_clean is unknown, using the team X-propagation macro.

Reset
REQ-024 SHALL, while rst is high at a rising edge, load s1 = s2 = 0, cnt = 0, btn_clean = 0, btn_press = 0, btn_release = 0 and press_count = 0.
REQ-025 SHALL give reset priority over every other update; reset mid-count discards the partial count, and no press or release pulse is generated by reset.
REQ-026 SHALL, on the first edge after rst deasserts, resume synchronizer sampling; a btn_raw held at 1 through reset yields btn_clean = 1 after N+2 edges, with one btn_press pulse.

Verification (N = 4 unless stated)
REQ-027 SHALL cover a clean press: rst for 2 cycles, then btn_raw 0->1 held -> btn_clean = 1 on edge 6 after the change, btn_press = 1 for that one cycle only, press_count = 1.
REQ-028 SHALL cover bounce rejection: btn_raw pulses of 1,2,3 cycles high separated by 4 cycles low -> btn_clean stays 0, no btn_press, press_count = 0.
REQ-029 SHALL cover a bouncy press: btn_raw toggles 1,0,1,0 each cycle, then held at 1 -> exactly one btn_press, 6 edges after the final 0->1; later release held at 0 -> exactly one btn_release.
REQ-030 SHALL cover saturation: 260 clean press/release cycles -> press_count reads 1,2,...,255, then stays 255.
REQ-031 SHALL cover reset mid-count: btn_raw = 1 for 3 cycles post-sync, then rst for 1 cycle -> all outputs 0; with btn_raw still 1, btn_clean = 1 six edges after rst deasserts.
REQ-032 SHALL cover the default parameter: N = 16 -> a 15-cycle glitch is rejected, and a 16-cycle stable level toggles btn_clean 18 edges after the btn_raw change.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer, stability counter, registered
// press/release pulses and a saturating press counter.
`ifndef XPROP_ASSIGN
`define XPROP_ASSIGN(sel, lhs) if ($isunknown(sel)) lhs = 'x;
`endif

module button_debouncer #(
  parameter int unsigned N = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_clean,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_count
);

  localparam int unsigned CW = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [7:0]    count_q, count_d;
  logic          btn_sync;

  assign btn_sync = s2_q;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    // Any agreement with the current level discards the partial count.
    if (btn_sync == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = btn_sync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    press_d   = clean_d & ~clean_q;
    release_d = ~clean_d & clean_q;

    if (press_d && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end

`ifndef SYNTHESIS
    `XPROP_ASSIGN({btn_sync, clean_q}, cnt_d)
    `XPROP_ASSIGN({btn_sync, clean_q}, clean_d)
    `XPROP_ASSIGN({btn_sync, clean_q}, press_d)
    `XPROP_ASSIGN({btn_sync, clean_q}, release_d)
    `XPROP_ASSIGN({btn_sync, clean_q}, count_d)
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign btn_clean   = clean_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign press_count = count_q;

`ifndef SYNTHESIS
  // Pulses are mutually exclusive and never back-to-back.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(press_q && release_q));
      assert (!(press_q && press_d));
      assert (!(release_q && release_d));
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: vector table plus multi-cycle sequences,
// N = 4 instance for most cases and an N = 16 instance for the default size.
module tb_button_debouncer;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       btn_clean;
  logic       btn_press;
  logic       btn_release;
  logic [7:0] press_count;

  logic       raw16;
  logic       clean16;
  logic       press16;
  logic       release16;
  logic [7:0] count16;

  int total = 0;
  int bad   = 0;

  button_debouncer #(.N(4)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_clean(btn_clean), .btn_press(btn_press),
    .btn_release(btn_release), .press_count(press_count)
  );

  button_debouncer #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .btn_raw(raw16),
    .btn_clean(clean16), .btn_press(press16),
    .btn_release(release16), .press_count(count16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       raw;
    logic       clean;
    logic       press;
    logic       rel;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic raw, input logic c,
                              input logic p, input logic rl, input logic [7:0] n);
    vec_t v;
    v.rst = r; v.raw = raw; v.clean = c; v.press = p; v.rel = rl; v.cnt = n;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npress, nrel, at, first;
    logic seen;

    rst = 1'b1; btn_raw = 1'b0; raw16 = 1'b0;

    // Clean press then clean release: change lands on edge 6.
    add(1,0, 0,0,0,0); add(1,0, 0,0,0,0);
    add(0,1, 0,0,0,0); add(0,1, 0,0,0,0); add(0,1, 0,0,0,0);
    add(0,1, 0,0,0,0); add(0,1, 0,0,0,0);
    add(0,1, 1,1,0,1); add(0,1, 1,0,0,1);
    add(0,0, 1,0,0,1); add(0,0, 1,0,0,1); add(0,0, 1,0,0,1);
    add(0,0, 1,0,0,1); add(0,0, 1,0,0,1);
    add(0,0, 0,0,1,1); add(0,0, 0,0,0,1);
    // Bounce rejection: 1, 2, 3 cycle pulses with 4 low cycles between.
    add(1,0, 0,0,0,0);
    add(0,1, 0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0, 0,0,0,0);
    for (int i = 0; i < 2; i++) add(0,1, 0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1, 0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      btn_raw = vecs[i].raw;
      tick();
      check($sformatf("vec[%0d]", i),
            {21'd0, btn_clean, btn_press, btn_release, press_count},
            {21'd0, vecs[i].clean, vecs[i].press, vecs[i].rel, vecs[i].cnt});
    end

    // Bouncy press: 1,0,1,0 then held high.
    npress = 0; at = 0;
    btn_raw = 1'b1; tick(); if (btn_press) npress++;
    btn_raw = 1'b0; tick(); if (btn_press) npress++;
    btn_raw = 1'b1; tick(); if (btn_press) npress++;
    btn_raw = 1'b0; tick(); if (btn_press) npress++;
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_press) begin npress++; at = k; end
    end
    check("bouncy_press_pulses", npress, 1);
    check("bouncy_press_edge", at, 6);
    check("bouncy_press_count", press_count, 8'd1);
    nrel = 0; at = 0;
    btn_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_release) begin nrel++; at = k; end
    end
    check("bouncy_release_pulses", nrel, 1);
    check("bouncy_release_edge", at, 6);
    check("bouncy_release_clean", btn_clean, 1'b0);

    // Saturation over 260 press/release cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    check("sat_reset_count", press_count, 8'd0);
    for (int i = 1; i <= 260; i++) begin
      btn_raw = 1'b1;
      repeat (8) tick();
      check($sformatf("sat_count[%0d]", i), press_count, (i > 255) ? 255 : i);
      btn_raw = 1'b0;
      repeat (8) tick();
    end

    // Reset arriving on the edge that would have switched btn_clean.
    btn_raw = 1'b1;
    repeat (5) tick();
    check("midrst_pre_clean", btn_clean, 1'b0);
    rst = 1'b1; tick();
    check("midrst_outputs", {btn_clean, btn_press, btn_release, press_count}, 11'd0);
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_clean && first == 0) begin
        first = k;
        check("midrst_press", btn_press, 1'b1);
      end
    end
    check("midrst_clean_edge", first, 6);
    check("midrst_count", press_count, 8'd1);

    // N = 16: 15-cycle glitch rejected, 16+ cycle level accepted on edge 18.
    raw16 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); if (clean16) seen = 1'b1; end
    raw16 = 1'b0;
    for (int k = 0; k < 30; k++) begin tick(); if (clean16) seen = 1'b1; end
    check("n16_glitch_rejected", seen, 1'b0);
    check("n16_glitch_count", count16, 8'd0);
    raw16 = 1'b1;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (clean16 && first == 0) begin
        first = k;
        check("n16_press", press16, 1'b1);
      end
    end
    check("n16_clean_edge", first, 18);
    check("n16_count", count16, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
